// File: rtl/memory_access.sv
// Memory-access pipeline stage: data-memory loads/stores over a req/ack bus, pass-through otherwise.
// Optional ack watchdog enabled by defining MEMORY_ACCESS_TIMEOUT_EN.
package memory_access_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] RD_ALU    = 2'd0;
  localparam logic [1:0] RD_MEMORY = 2'd1;
  localparam logic [1:0] RD_PC     = 2'd2;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef struct packed {
    logic       memory_we;
    logic [1:0] reg_rd_src;
    logic [1:0] memory_mask;
    logic       sign_ext;
    logic       ebreak;
  } instruction_t;

  typedef struct packed {
    logic [REG_AW-1:0] target;
    logic [XLEN-1:0]   value;
    logic [XLEN-1:0]   store_value;
  } stage_data_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    instruction_t    instruction;
    stage_data_t     data;
  } stage_status_t;

  typedef struct packed {
    logic [REG_AW-1:0] target;
    logic [XLEN-1:0]   value;
    logic              valid;
  } forwarding_data_status_t;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  stage_status_t           stage_in,
  output stage_status_t           stage_out,
  output forwarding_data_status_t data_out,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [XLEN-1:0]         mem_address,
  output logic [3:0]              mem_byte_en,
  output logic [XLEN-1:0]         mem_write_data,
  input  logic                    mem_ack,
  input  logic [XLEN-1:0]         mem_read_data,
  output logic                    misaligned,
  output logic                    bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_DONE} state_t;

  state_t          r_state, w_next_state;
  stage_status_t   r_stage;
  logic            r_squash;
  logic [XLEN-1:0] r_load;
  logic            r_mem_req;
  logic            r_misaligned;

  logic            w_mem_op, w_accept, w_misalign_in;
  logic            w_timeout, w_timed_out;
  logic [1:0]      w_lane;
  logic [XLEN-1:0] w_shifted, w_load_aligned;
  logic            w_store, w_squash_done;
  logic            w_unused;

  assign w_unused = ^{stage_in.ready, 32'(TIMEOUT_CYCLES)};

  assign w_mem_op = stage_in.valid &&
                    (stage_in.instruction.memory_we || stage_in.instruction.reg_rd_src == RD_MEMORY);
  assign w_accept = w_mem_op && !flush && (r_state != S_WAIT_ACK);
  assign w_misalign_in =
      ((stage_in.instruction.memory_mask == MASK_HALF) && stage_in.data.value[0]) ||
      (stage_in.instruction.memory_mask[1] && (stage_in.data.value[1:0] != 2'b00));

`ifdef MEMORY_ACCESS_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timed_out;
  logic             r_bus_error;

  assign w_timeout   = (r_state == S_WAIT_ACK) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timed_out = r_timed_out;
  assign bus_error   = r_bus_error;

  // Ack watchdog: counts cycles spent in WAIT_ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_cnt       <= (r_state == S_WAIT_ACK) ? r_cnt + CNT_W'(1) : '0;
      r_bus_error <= w_timeout;
      if (w_accept)
        r_timed_out <= 1'b0;
      else if (w_timeout)
        r_timed_out <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_timed_out = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // Lane selection and load alignment from the latched address
  always_comb begin
    w_lane = 2'b00;
    case (r_stage.instruction.memory_mask)
      MASK_BYTE: w_lane = r_stage.data.value[1:0];
      MASK_HALF: w_lane = {r_stage.data.value[1], 1'b0};
      default:   w_lane = 2'b00;
    endcase
    w_shifted      = mem_read_data >> {w_lane, 3'b000};
    w_load_aligned = mem_read_data;
    case (r_stage.instruction.memory_mask)
      MASK_BYTE: w_load_aligned = {{24{r_stage.instruction.sign_ext & w_shifted[7]}}, w_shifted[7:0]};
      MASK_HALF: w_load_aligned = {{16{r_stage.instruction.sign_ext & w_shifted[15]}}, w_shifted[15:0]};
      default:   w_load_aligned = mem_read_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next_state = w_misalign_in ? S_DONE : S_WAIT_ACK;
      S_WAIT_ACK: if (mem_ack || w_timeout) w_next_state = S_DONE;
      S_DONE:     if (w_accept) w_next_state = w_misalign_in ? S_DONE : S_WAIT_ACK;
                  else          w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Instruction latch, load capture and bus request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage      <= '0;
      r_squash     <= 1'b0;
      r_load       <= '0;
      r_mem_req    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_mem_req    <= (w_next_state == S_WAIT_ACK);
      r_misaligned <= w_accept && w_misalign_in;
      if (w_accept) begin
        r_stage  <= stage_in;
        r_squash <= 1'b0;
        r_load   <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        if (flush)   r_squash <= 1'b1;
        if (mem_ack) r_load   <= w_load_aligned;
      end
    end
  end

  assign w_store       = r_stage.instruction.memory_we;
  assign w_squash_done = r_squash || flush;

  always_comb begin
    stage_out       = stage_in;
    stage_out.ready = 1'b1;
    data_out.target = stage_in.data.target;
    data_out.value  = stage_in.data.value;
    data_out.valid  = stage_in.valid && (stage_in.data.target != '0);
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          stage_out.valid = 1'b0;
          stage_out.ready = !w_accept;
          data_out.valid  = 1'b0;
        end
      end
      S_WAIT_ACK: begin
        stage_out       = r_stage;
        stage_out.valid = 1'b0;
        stage_out.ready = 1'b0;
        data_out.target = r_stage.data.target;
        data_out.value  = '0;
        data_out.valid  = 1'b0;
      end
      S_DONE: begin
        stage_out                    = r_stage;
        stage_out.valid              = !w_squash_done;
        stage_out.ready              = 1'b1;
        stage_out.instruction.ebreak = r_stage.instruction.ebreak | w_timed_out;
        stage_out.data.value         = w_store ? r_stage.data.value : r_load;
        stage_out.data.target        = (w_store || w_squash_done) ? '0 : r_stage.data.target;
        data_out.target              = stage_out.data.target;
        data_out.value               = w_store ? '0 : r_load;
        data_out.valid               = !w_store && !w_squash_done && (r_stage.data.target != '0);
      end
      default: ;
    endcase
  end

  // Bus outputs are held at zero whenever no request is outstanding
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_req & r_stage.instruction.memory_we;
  assign mem_address    = r_mem_req ? {r_stage.data.value[XLEN-1:2], 2'b00} : '0;
  assign misaligned     = r_misaligned;
  assign mem_byte_en    = !r_mem_req ? 4'b0000 :
                          (r_stage.instruction.memory_mask == MASK_BYTE) ? (4'b0001 << w_lane) :
                          (r_stage.instruction.memory_mask == MASK_HALF) ? (4'b0011 << w_lane) : 4'b1111;
  assign mem_write_data = !r_mem_req ? '0 :
                          (r_stage.instruction.memory_mask == MASK_BYTE) ? {4{r_stage.data.store_value[7:0]}} :
                          (r_stage.instruction.memory_mask == MASK_HALF) ? {2{r_stage.data.store_value[15:0]}} :
                          r_stage.data.store_value;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: vector table for pass-through, hand sequences for bus ops.
module tb_memory_access;
  import memory_access_pkg::*;

`ifdef MEMORY_ACCESS_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  stage_status_t           si;
  stage_status_t           so;
  forwarding_data_status_t fwd;
  logic                    mem_req, mem_we, mem_ack, misaligned, bus_error;
  logic [31:0]             mem_address, mem_write_data, mem_read_data;
  logic [3:0]              mem_byte_en;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stage_in(si), .stage_out(so), .data_out(fwd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address), .mem_byte_en(mem_byte_en),
    .mem_write_data(mem_write_data), .mem_ack(mem_ack), .mem_read_data(mem_read_data),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        we;
    logic [1:0]  rd_src;
    logic        fl;
    logic [4:0]  tgt;
    logic [31:0] val;
    logic        exp_valid;
    logic        exp_ready;
    logic        exp_fwd_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic valid, input logic we, input logic [1:0] rd_src,
                        input logic [1:0] mask, input logic sx, input logic [31:0] addr,
                        input logic [4:0] tgt, input logic [31:0] sdata);
    si                         = '0;
    si.valid                   = valid;
    si.pc                      = 32'h0000_1000;
    si.instruction.memory_we   = we;
    si.instruction.reg_rd_src  = rd_src;
    si.instruction.memory_mask = mask;
    si.instruction.sign_ext    = sx;
    si.data.target             = tgt;
    si.data.value              = addr;
    si.data.store_value        = sdata;
  endtask

  // One aligned bus op; waits = number of WAIT_ACK cycles, ack given in the last
  task automatic mem_op(input string nm, input logic we, input logic [1:0] mask, input logic sx,
                        input logic [31:0] addr, input logic [4:0] tgt, input logic [31:0] sdata,
                        input int waits, input logic [31:0] rdata, input logic [31:0] exp_val,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    set_op(1'b1, we, we ? RD_ALU : RD_MEMORY, mask, sx, addr, tgt, sdata);
    @(negedge clk);
    chk({nm, " idle ready"}, 32'(so.ready), 32'd0);
    chk({nm, " idle fwd valid"}, 32'(fwd.valid), 32'd0);
    chk({nm, " idle mem_req"}, 32'(mem_req), 32'd0);
    next_cycle();
    si.valid = 1'b0;
    for (int i = 1; i <= waits; i++) begin
      @(negedge clk);
      chk({nm, " wait mem_req"}, 32'(mem_req), 32'd1);
      chk({nm, " wait ready"}, 32'(so.ready), 32'd0);
      chk({nm, " wait fwd valid"}, 32'(fwd.valid), 32'd0);
      if (i == 1) begin
        chk({nm, " address"}, mem_address, {addr[31:2], 2'b00});
        chk({nm, " byte_en"}, 32'(mem_byte_en), 32'(exp_be));
        chk({nm, " we"}, 32'(mem_we), 32'(we));
        if (we) chk({nm, " write_data"}, mem_write_data, exp_wd);
      end
      if (i == waits) begin
        mem_ack       = 1'b1;
        mem_read_data = rdata;
      end
      next_cycle();
      mem_ack       = 1'b0;
      mem_read_data = 32'h0;
    end
    @(negedge clk);
    chk({nm, " done valid"}, 32'(so.valid), 32'd1);
    chk({nm, " done ready"}, 32'(so.ready), 32'd1);
    chk({nm, " done mem_req"}, 32'(mem_req), 32'd0);
    chk({nm, " done out target"}, 32'(so.data.target), we ? 32'd0 : 32'(tgt));
    chk({nm, " done fwd target"}, 32'(fwd.target), we ? 32'd0 : 32'(tgt));
    chk({nm, " done fwd valid"}, 32'(fwd.valid), 32'((!we) && (tgt != 5'd0)));
    if (!we) chk({nm, " done value"}, fwd.value, exp_val);
    next_cycle();
  endtask

  initial begin
    si            = '0;
    mem_ack       = 1'b0;
    mem_read_data = 32'h0;

    vecs[0] = '{1'b1, 1'b0, RD_ALU,    1'b0, 5'd3,  32'h1234_5678, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, RD_ALU,    1'b0, 5'd0,  32'h0000_00AA, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, RD_ALU,    1'b0, 5'd9,  32'h0000_0042, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, RD_PC,     1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, RD_MEMORY, 1'b1, 5'd4,  32'h0000_0100, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, RD_ALU,    1'b1, 5'd6,  32'h0000_0200, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    chk("reset bus_error", 32'(bus_error), 32'd0);
    chk("reset fwd valid", 32'(fwd.valid), 32'd0);
    chk("reset ready", 32'(so.ready), 32'd1);
    next_cycle();
    rst = 1'b0;

    // Pass-through and flushed-in-IDLE vectors
    for (int v = 0; v < 6; v++) begin
      set_op(vecs[v].valid, vecs[v].we, vecs[v].rd_src, MASK_WORD, 1'b0, vecs[v].val, vecs[v].tgt, 32'h0);
      flush = vecs[v].fl;
      @(negedge clk);
      chk($sformatf("vec%0d valid", v), 32'(so.valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d ready", v), 32'(so.ready), 32'(vecs[v].exp_ready));
      chk($sformatf("vec%0d fwd target", v), 32'(fwd.target), 32'(vecs[v].tgt));
      chk($sformatf("vec%0d fwd value", v), fwd.value, vecs[v].val);
      chk($sformatf("vec%0d fwd valid", v), 32'(fwd.valid), 32'(vecs[v].exp_fwd_valid));
      chk($sformatf("vec%0d mem_req", v), 32'(mem_req), 32'd0);
      next_cycle();
    end
    flush = 1'b0;
    si    = '0;
    @(negedge clk);
    chk("flushed op not latched", 32'(mem_req), 32'd0);
    next_cycle();

    // Aligned bus operations
    mem_op("lw 0x100",  1'b0, MASK_WORD, 1'b0, 32'h100, 5'd5, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0);
    mem_op("lb 0x103",  1'b0, MASK_BYTE, 1'b1, 32'h103, 5'd6, 32'h0, 1, 32'h80112233, 32'hFFFFFF80, 4'b1000, 32'h0);
    mem_op("lbu 0x103", 1'b0, MASK_BYTE, 1'b0, 32'h103, 5'd6, 32'h0, 1, 32'h80112233, 32'h00000080, 4'b1000, 32'h0);
    mem_op("sh 0x202",  1'b1, MASK_HALF, 1'b0, 32'h202, 5'd9, 32'h1234ABCD, 1, 32'h0, 32'h0, 4'b1100, 32'hABCDABCD);
    mem_op("lh 0x002",  1'b0, MASK_HALF, 1'b1, 32'h002, 5'd10, 32'h0, 3, 32'h80017FFF, 32'hFFFF8001, 4'b1100, 32'h0);
    mem_op("sb 0x011",  1'b1, MASK_BYTE, 1'b0, 32'h011, 5'd2, 32'h000000A5, 1, 32'h0, 32'h0, 4'b0010, 32'hA5A5A5A5);

    // Misaligned word load: no bus request, result 0
    set_op(1'b1, 1'b0, RD_MEMORY, MASK_WORD, 1'b0, 32'h101, 5'd5, 32'h0);
    mem_read_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("misal idle mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    si.valid = 1'b0;
    @(negedge clk);
    chk("misal pulse", 32'(misaligned), 32'd1);
    chk("misal mem_req", 32'(mem_req), 32'd0);
    chk("misal done valid", 32'(so.valid), 32'd1);
    chk("misal fwd valid", 32'(fwd.valid), 32'd1);
    chk("misal fwd target", 32'(fwd.target), 32'd5);
    chk("misal result", fwd.value, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("misal pulse ends", 32'(misaligned), 32'd0);
    chk("misal after mem_req", 32'(mem_req), 32'd0);
    mem_read_data = 32'h0;
    next_cycle();

    // Flush in the second WAIT_ACK cycle
    set_op(1'b1, 1'b0, RD_MEMORY, MASK_WORD, 1'b0, 32'h100, 5'd7, 32'h0);
    next_cycle();
    si.valid = 1'b0;
    @(negedge clk);
    chk("flush wait1 mem_req", 32'(mem_req), 32'd1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush wait2 mem_req", 32'(mem_req), 32'd1);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush wait3 mem_req held", 32'(mem_req), 32'd1);
    mem_ack       = 1'b1;
    mem_read_data = 32'h0000_0055;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("flush done valid", 32'(so.valid), 32'd0);
    chk("flush done fwd valid", 32'(fwd.valid), 32'd0);
    chk("flush done fwd target", 32'(fwd.target), 32'd0);
    chk("flush done mem_req", 32'(mem_req), 32'd0);
    next_cycle();

    // Reset mid-WAIT_ACK drops mem_req immediately
    set_op(1'b1, 1'b0, RD_MEMORY, MASK_WORD, 1'b0, 32'h400, 5'd8, 32'h0);
    next_cycle();
    si.valid = 1'b0;
    @(negedge clk);
    chk("rst pre mem_req", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst async mem_req", 32'(mem_req), 32'd0);
    chk("rst async fwd valid", 32'(fwd.valid), 32'd0);
    #1 rst = 1'b0;
    next_cycle();
    set_op(1'b1, 1'b0, RD_ALU, MASK_WORD, 1'b0, 32'h0000_0077, 5'd2, 32'h0);
    @(negedge clk);
    chk("post rst passthrough fwd valid", 32'(fwd.valid), 32'd1);
    chk("post rst passthrough value", fwd.value, 32'h77);
    chk("post rst ready", 32'(so.ready), 32'd1);
    chk("post rst mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    si = '0;

`ifdef MEMORY_ACCESS_TIMEOUT_EN
    // Ack never arrives: watchdog fires after TB_TO wait cycles
    set_op(1'b1, 1'b0, RD_MEMORY, MASK_WORD, 1'b0, 32'h300, 5'd8, 32'h0);
    next_cycle();
    si.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to wait mem_req", 32'(mem_req), 32'd1);
      chk("to wait bus_error", 32'(bus_error), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to bus_error", 32'(bus_error), 32'd1);
    chk("to ebreak", 32'(so.instruction.ebreak), 32'd1);
    chk("to mem_req", 32'(mem_req), 32'd0);
    chk("to done valid", 32'(so.valid), 32'd1);
    chk("to result", fwd.value, 32'h0);
    next_cycle();
    mem_ack       = 1'b1;
    mem_read_data = 32'h1234_5678;
    @(negedge clk);
    chk("to late ack mem_req", 32'(mem_req), 32'd0);
    chk("to bus_error ends", 32'(bus_error), 32'd0);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("to late ack ignored", 32'(mem_req), 32'd0);
`else
    @(negedge clk);
    chk("bus_error tied low", 32'(bus_error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
